// File: rtl/arcade_input_ctrl_if.sv
// Signal bundle between the emu top level and arcade_input_ctrl.
// master drives the raw inputs and receives conditioned controls; slave is arcade_input_ctrl.
interface arcade_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        rotate;
    logic [4:0]  p1_ctrl;
    logic [4:0]  p2_ctrl;
    logic        start1;
    logic        start2;
    logic        test;
    logic        coin1;
    logic [2:0]  coin_pending;

    modport master (
        output ps2_key, joystick_0, joystick_1, rotate,
        input  p1_ctrl, p2_ctrl, start1, start2, test, coin1, coin_pending
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, rotate,
        output p1_ctrl, p2_ctrl, start1, start2, test, coin1, coin_pending
    );
endinterface

// File: rtl/arcade_input_ctrl.sv
// PS/2 + joystick input conditioning for burnin_rubber: key decode, merge, rotate remap, coin pulser.
// Optional autofire on both fire buttons when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_ctrl #(
    parameter int unsigned CLK_HZ  = 12000000,
    parameter int unsigned COIN_MS = 100,
    parameter int unsigned GAP_MS  = 100,
    parameter int unsigned QDEPTH  = 3
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    ,
    parameter int unsigned AUTOFIRE_MS = 50
`endif
) (
    input  logic                clk_sys,
    input  logic                reset_n,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  logic                autofire,
`endif
    arcade_input_ctrl_if.slave  bus
);

    localparam int unsigned   PRESC_TC   = (CLK_HZ / 1000) - 1;
    localparam int unsigned   PW         = (PRESC_TC < 1) ? 1 : $clog2(PRESC_TC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_TC);
    localparam logic [7:0]    COIN_LAST  = 8'(COIN_MS - 1);
    localparam logic [7:0]    GAP_LAST   = 8'(GAP_MS - 1);
    localparam logic [2:0]    QMAX       = 3'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    logic          tog_q;
    logic          key_ev;
    logic          pressed;
    logic          ext;
    logic [7:0]    code;
    logic [4:0]    k1_q, k1_d, k2_q, k2_d;
    logic          ks1_q, ks1_d, ks2_q, ks2_d, kt_q, kt_d, kc_q, kc_d;
    logic [15:0]   joy;
    logic          unused_joy;
    logic [4:0]    raw1, raw2;
    logic [1:0]    raw_fire, fire_eff;
    logic [4:0]    p1_d, p2_d, p1_q, p2_q;
    logic          start1_d, start2_d;
    logic          start1_q, start2_q, test_q;
    logic          lvl_q, lvl_dq, coin_req;
    logic [PW-1:0] presc_q;
    logic          tick;
    coin_state_t   state_q, state_d;
    logic [7:0]    ms_q, ms_d;
    logic          deq;
    logic          coin1_q;
    logic [2:0]    queue_q, queue_d;

    function automatic logic [4:0] orient(input logic [4:0] v, input logic rot);
        // {fire,up,down,left,right}: up<-left, down<-right, left<-down, right<-up
        return rot ? {v[4], v[1], v[0], v[2], v[3]} : v;
    endfunction

    assign pressed = bus.ps2_key[9];
    assign ext     = bus.ps2_key[8];
    assign code    = bus.ps2_key[7:0];
    assign key_ev  = bus.ps2_key[10] ^ tog_q;

    always_comb begin
        k1_d  = k1_q;
        k2_d  = k2_q;
        ks1_d = ks1_q;
        ks2_d = ks2_q;
        kt_d  = kt_q;
        kc_d  = kc_q;
        if (key_ev) begin
            case (code)
                8'h75: k1_d[3] = pressed;
                8'h72: k1_d[2] = pressed;
                8'h6B: k1_d[1] = pressed;
                8'h74: k1_d[0] = pressed;
                8'h14: k1_d[4] = pressed;
                default: begin
                    if (!ext) begin
                        case (code)
                            8'h29:        k1_d[4] = pressed;
                            8'h05, 8'h16: ks1_d   = pressed;
                            8'h06, 8'h1E: ks2_d   = pressed;
                            8'h2E, 8'h36: kc_d    = pressed;
                            8'h2D:        k2_d[3] = pressed;
                            8'h2B:        k2_d[2] = pressed;
                            8'h23:        k2_d[1] = pressed;
                            8'h34:        k2_d[0] = pressed;
                            8'h1C:        k2_d[4] = pressed;
                            8'h2C:        kt_d    = pressed;
                            default:      ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign joy        = bus.joystick_0 | bus.joystick_1;
    assign unused_joy = ^joy[15:7];
    assign raw1       = k1_q | joy[4:0];
    assign raw2       = k2_q | joy[4:0];
    assign raw_fire   = {raw2[4], raw1[4]};

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [1:0]  af_prev_q;
    logic [1:0]  af_phase_q;
    logic [15:0] af_cnt_q [2];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_prev_q  <= '0;
            af_phase_q <= '0;
            af_cnt_q   <= '{default: '0};
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                af_prev_q[p] <= raw_fire[p];
                if (!raw_fire[p]) begin
                    af_phase_q[p] <= 1'b0;
                    af_cnt_q[p]   <= '0;
                end else if (!af_prev_q[p]) begin
                    af_phase_q[p] <= 1'b1;
                    af_cnt_q[p]   <= '0;
                end else if (tick) begin
                    if (af_cnt_q[p] == 16'(AUTOFIRE_MS - 1)) begin
                        af_phase_q[p] <= ~af_phase_q[p];
                        af_cnt_q[p]   <= '0;
                    end else begin
                        af_cnt_q[p] <= af_cnt_q[p] + 16'd1;
                    end
                end
            end
        end
    end

    // The press cycle itself reads as 1 before the phase register has caught up.
    always_comb begin
        fire_eff = raw_fire;
        if (autofire) begin
            for (int unsigned p = 0; p < 2; p++) begin
                fire_eff[p] = raw_fire[p] & (~af_prev_q[p] | af_phase_q[p]);
            end
        end
    end
`else
    assign fire_eff = raw_fire;
`endif

    assign p1_d     = orient({fire_eff[0], raw1[3:0]}, bus.rotate);
    assign p2_d     = orient({fire_eff[1], raw2[3:0]}, bus.rotate);
    assign start1_d = ks1_q | joy[5];
    assign start2_d = ks2_q | joy[6];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q    <= 1'b0;
            k1_q     <= '0;
            k2_q     <= '0;
            ks1_q    <= 1'b0;
            ks2_q    <= 1'b0;
            kt_q     <= 1'b0;
            kc_q     <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
            test_q   <= 1'b0;
            lvl_q    <= 1'b0;
            lvl_dq   <= 1'b0;
        end else begin
            tog_q    <= bus.ps2_key[10];
            k1_q     <= k1_d;
            k2_q     <= k2_d;
            ks1_q    <= ks1_d;
            ks2_q    <= ks2_d;
            kt_q     <= kt_d;
            kc_q     <= kc_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            start1_q <= start1_d;
            start2_q <= start2_d;
            test_q   <= kt_q;
            lvl_q    <= start1_d | start2_d | kc_q;
            lvl_dq   <= lvl_q;
        end
    end

    assign coin_req = lvl_q & ~lvl_dq;

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        deq     = 1'b0;
        case (state_q)
            IDLE: begin
                if (queue_q != '0) begin
                    state_d = PULSE;
                    ms_d    = '0;
                    deq     = 1'b1;
                end
            end
            PULSE: begin
                if (tick) begin
                    if (ms_q == COIN_LAST) begin
                        state_d = GAP;
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_q + 8'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (ms_q == GAP_LAST) begin
                        state_d = IDLE;
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request coinciding with a dequeue nets out, even when the queue is full.
    always_comb begin
        queue_d = queue_q;
        if (deq && !coin_req) begin
            queue_d = queue_q - 3'd1;
        end else if (coin_req && !deq && (queue_q < QMAX)) begin
            queue_d = queue_q + 3'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ms_q    <= '0;
            coin1_q <= 1'b0;
            queue_q <= '0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            coin1_q <= (state_d == PULSE);
            queue_q <= queue_d;
        end
    end

    assign bus.p1_ctrl      = p1_q;
    assign bus.p2_ctrl      = p2_q;
    assign bus.start1       = start1_q;
    assign bus.start2       = start2_q;
    assign bus.test         = test_q;
    assign bus.coin1        = coin1_q;
    assign bus.coin_pending = queue_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl: directed scenarios plus randomized key/joystick traffic
// compared every cycle against a rule-level reference model.
module tb_arcade_input_ctrl;
    localparam int unsigned COIN_MS = 4;
    localparam int unsigned GAP_MS  = 3;
    localparam int unsigned QDEPTH  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tog   = 1'b0;
    always #5 clk = ~clk;

    arcade_input_ctrl_if bus();

    arcade_input_ctrl #(
        .CLK_HZ (1000),
        .COIN_MS(COIN_MS),
        .GAP_MS (GAP_MS),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        .autofire(1'b0),
`endif
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    bit coin_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_event(input logic p, input logic x, input logic [7:0] c);
        tog = ~tog;
        bus.ps2_key = {tog, p, x, c};
    endtask

    // ---------------- reference model ----------------
    // Key functions: 0..4 P1 {right,left,down,up,fire}, 5..9 P2 same, 10 start1, 11 start2, 12 test, 13 coin
    function automatic int key_fn(input logic [7:0] c, input logic x);
        case (c)
            8'h74: return 0;
            8'h6B: return 1;
            8'h72: return 2;
            8'h75: return 3;
            8'h14: return 4;
            default: ;
        endcase
        if (x) return -1;
        case (c)
            8'h29:        return 4;
            8'h34:        return 5;
            8'h23:        return 6;
            8'h2B:        return 7;
            8'h2D:        return 8;
            8'h1C:        return 9;
            8'h05, 8'h16: return 10;
            8'h06, 8'h1E: return 11;
            8'h2C:        return 12;
            8'h2E, 8'h36: return 13;
            default:      return -1;
        endcase
    endfunction

    function automatic logic [4:0] tb_orient(input logic [4:0] v, input logic r);
        logic f, u, d, l, rt;
        {f, u, d, l, rt} = v;
        if (r) return {f, l, rt, d, u};
        return v;
    endfunction

    bit [13:0] mk;
    bit        m_tog;
    bit [4:0]  e_p1, e_p2;
    bit        e_s1, e_s2, e_test, e_coin1;
    int        e_pend;
    bit        lvl_q, lvl_qq;
    longint    now, pulse_end, free_at;

    always @(posedge clk) begin
        logic [15:0] joy;
        bit req, deq;
        if (!rst_n) begin
            mk = '0; m_tog = 1'b0;
            e_p1 = '0; e_p2 = '0; e_s1 = 0; e_s2 = 0; e_test = 0; e_coin1 = 0;
            e_pend = 0; lvl_q = 0; lvl_qq = 0;
            now = 0; pulse_end = -1; free_at = 0;
        end else begin
            joy    = bus.joystick_0 | bus.joystick_1;
            e_p1   = tb_orient(mk[4:0] | joy[4:0], bus.rotate);
            e_p2   = tb_orient(mk[9:5] | joy[4:0], bus.rotate);
            e_s1   = mk[10] | joy[5];
            e_s2   = mk[11] | joy[6];
            e_test = mk[12];
            req    = lvl_q & !lvl_qq;
            lvl_qq = lvl_q;
            lvl_q  = e_s1 | e_s2 | mk[13];
            // coin timing: 1 tick per clock, pulse COIN_MS, gap GAP_MS, one idle clock before next dequeue
            if (now == pulse_end) e_coin1 = 0;
            deq = (now >= free_at) && (e_pend > 0);
            if (deq) begin
                e_coin1   = 1;
                pulse_end = now + COIN_MS;
                free_at   = now + COIN_MS + GAP_MS + 1;
                e_pend--;
            end
            if (req && e_pend < QDEPTH) e_pend++;
            if (bus.ps2_key[10] != m_tog) begin
                int f;
                f = key_fn(bus.ps2_key[7:0], bus.ps2_key[8]);
                if (f >= 0) mk[f] = bus.ps2_key[9];
            end
            m_tog = bus.ps2_key[10];
            now++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("p1_ctrl", bus.p1_ctrl, e_p1);
            check("p2_ctrl", bus.p2_ctrl, e_p2);
            check("start1", bus.start1, e_s1);
            check("start2", bus.start2, e_s2);
            check("test", bus.test, e_test);
            check("coin1", bus.coin1, e_coin1);
            check("coin_pending", bus.coin_pending, e_pend);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) coin_prev = 1'b0;
        else begin
            if (bus.coin1 && !coin_prev) n_pulses++;
            coin_prev = bus.coin1;
        end
    end

    logic [7:0] codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h05, 8'h16, 8'h06, 8'h1E,
                               8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h2C, 8'h1A, 8'h4A};

    initial begin
        int hi;
        bus.ps2_key = '0; bus.joystick_0 = '0; bus.joystick_1 = '0; bus.rotate = 1'b0;

        // reset state
        step(3);
        check("rst_p1", bus.p1_ctrl, 0);
        check("rst_p2", bus.p2_ctrl, 0);
        check("rst_start", {bus.start1, bus.start2, bus.test}, 0);
        check("rst_coin1", bus.coin1, 0);
        check("rst_pending", bus.coin_pending, 0);
        rst_n = 1'b1;
        step(2);

        // key decode: extended up arrow, 2-clock latency
        ps2_event(1, 1, 8'h75); step;
        check("key_lat1", bus.p1_ctrl, 5'b00000);
        step;
        check("key_up", bus.p1_ctrl, 5'b01000);
        ps2_event(0, 1, 8'h75); step(2);
        check("key_up_rel", bus.p1_ctrl, 5'b00000);
        bus.ps2_key = {tog, 1'b1, 1'b1, 8'h75}; step(3);
        check("key_no_toggle", bus.p1_ctrl, 5'b00000);
        ps2_event(1, 1, 8'h29); step(2);
        check("key_ext_space", bus.p1_ctrl, 5'b00000);
        ps2_event(1, 0, 8'h29); step(2);
        check("key_space", bus.p1_ctrl, 5'b10000);
        ps2_event(0, 0, 8'h29); step(2);

        // rotate remap
        bus.rotate = 1'b1; bus.joystick_0 = 16'h0002; step;
        check("rot_p1", bus.p1_ctrl, 5'b01000);
        check("rot_p2", bus.p2_ctrl, 5'b01000);
        bus.rotate = 1'b0; step;
        check("norot_p1", bus.p1_ctrl, 5'b00010);
        check("norot_p2", bus.p2_ctrl, 5'b00010);
        bus.joystick_0 = '0; step(12);

        // coin timing from one start1 press
        bus.joystick_0 = 16'h0020; step;
        check("start1_joy", bus.start1, 1);
        step;
        check("coin_q1", bus.coin_pending, 1);
        check("coin_pre", bus.coin1, 0);
        step;
        check("coin_q0", bus.coin_pending, 0);
        check("coin_start", bus.coin1, 1);
        bus.joystick_0 = '0;
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            step;
            if (bus.coin1) hi++;
            else break;
        end
        check("coin_width_ok", (hi >= COIN_MS - 1) && (hi <= COIN_MS + 1), 1);
        for (int i = 0; i < GAP_MS - 1; i++) begin
            step;
            check("coin_gap_low", bus.coin1, 0);
        end
        step(12);

        // queue saturation: 5 coin presses -> 1 + QDEPTH pulses
        n_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            ps2_event(1, 0, 8'h2E); step;
            ps2_event(0, 0, 8'h2E); step;
        end
        check("queue_sat", bus.coin_pending, QDEPTH);
        step(60);
        check("queue_pulses", n_pulses, 1 + QDEPTH);
        check("queue_empty", bus.coin_pending, 0);

        // request landing on the dequeue edge with queue=1
        ps2_event(1, 0, 8'h36); step;
        ps2_event(0, 0, 8'h36); step;
        ps2_event(1, 0, 8'h36); step;
        ps2_event(0, 0, 8'h36); step(6);
        ps2_event(1, 0, 8'h36); step;
        ps2_event(0, 0, 8'h36); step(2);
        check("sim_pending", bus.coin_pending, 1);
        check("sim_coin", bus.coin1, 1);
        step(4);
        check("sim_gap", bus.coin1, 0);
        step(4);
        check("sim_next", bus.coin1, 1);
        check("sim_pending0", bus.coin_pending, 0);
        step(20);

        // reset mid-pulse with a queued request
        bus.joystick_0 = 16'h0040; step;
        bus.joystick_0 = '0; step;
        bus.joystick_0 = 16'h0040; step;
        bus.joystick_0 = '0; step;
        check("mid_coin", bus.coin1, 1);
        check("mid_pending", bus.coin_pending, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_coin", bus.coin1, 0);
        check("rst_async_q", bus.coin_pending, 0);
        step(2);
        rst_n = 1'b1;
        step;
        check("post_rst_coin", bus.coin1, 0);
        check("post_rst_q", bus.coin_pending, 0);
        check("post_rst_ctrl", {bus.p1_ctrl, bus.p2_ctrl, bus.start1, bus.start2, bus.test}, 0);

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 35) ps2_event(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), codes[$urandom_range(0, 19)]);
            else if (r < 45) bus.ps2_key[9:0] = 10'($urandom);
            if ($urandom_range(0, 7) == 0) bus.joystick_0 = 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.joystick_1 = 16'($urandom);
            if ($urandom_range(0, 31) == 0) bus.rotate = ~bus.rotate;
            step;
        end
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Input-conditioning stage directly upstream of the game core (burnin_rubber), in the emu top level.
- Decodes the hps_io PS/2 key event stream into held-key state and merges it with both joysticks.
- Applies the horizontal-orientation control remap and produces core-ready P1/P2 control, start, test and coin signals.
- Coin is a timed pulse with gap lockout and a bounded request queue; the core must never see a coin line held indefinitely or retriggered faster than it samples.

Parameters:
- CLK_HZ, 12000000, clk_sys frequency in Hz; sets the 1 ms prescaler terminal count (CLK_HZ/1000 - 1).
- COIN_MS, 100, coin pulse high time in ms (1..255).
- GAP_MS, 100, minimum coin low time between pulses in ms (1..255).
- QDEPTH, 3, maximum queued coin requests (saturating, 1..7).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended, [7:0] scancode.
- joystick_0  in  16  [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2.
- joystick_1  in  16  same layout.
- rotate  in  1  1 = horizontal orientation remap (status[2]).
- p1_ctrl  out  5  {fire,up,down,left,right}, registered.
- p2_ctrl  out  5  same, player 2.
- start1  out  1  registered.
- start2  out  1  registered.
- test  out  1  registered.
- coin1  out  1  timed coin pulse.
- coin_pending  out  3  queued coin request count.

Behaviour:
- Reset: all outputs 0; all key states 0; toggle-history register = 0; FSM = IDLE; queue = 0; prescaler = 0.
- Key decode:
  - An event exists when ps2_key[10] differs from the registered previous value of ps2_key[10].
  - Process at most one event per clock; state update is visible on the next clock.
  - Extended bit is ignored for arrows (75 up, 72 down, 6B left, 74 right) and for 14 (ctrl = P1 fire). All other keys require ps2_key[8]=0.
  - Key map: 29 space = P1 fire; 05 F1 and 16 "1" = start1; 06 F2 and 1E "2" = start2; 2E "5" and 36 "6" = coin; 2D/2B/23/34 = P2 up/down/left/right; 1C = P2 fire; 2C = test.
  - Unmapped codes are ignored.
  - A press sets the key state to 1 and a release clears it; repeated presses are idempotent.
- Merge:
  - raw P1 = P1 keys OR (joystick_0 | joystick_1).
  - raw P2 = P2 keys OR (joystick_0 | joystick_1).
- Rotate remap (rotate=1): up←left, down←right, left←down, right←up, applied to each player's own merged signals. Fire is unaffected.
- Start outputs:
  - start1 = key start1 | joy[5].
  - start2 = key start2 | joy[6].
- Output timing:
  - All control outputs are registered, one cycle after merge.
  - Total latency from a ps2 toggle to the output is 2 clocks.
  - Total latency from a joystick change to the output is 1 clock.
- Coin request: one request per rising edge of (start1 | start2 | coin key), edge-detected on the registered signal.
- Prescaler: 1 ms tick, free-running from reset.
- Coin FSM:
  - IDLE: if queue>0 → PULSE, decrement queue, coin1=1, ms counter=0.
  - PULSE: count ticks; at COIN_MS ticks → GAP, coin1=0.
  - GAP: at GAP_MS ticks → IDLE.
  - A partial first ms is accepted (±1 ms tolerance).
- Queue rules:
  - Increments on request, saturating at QDEPTH; excess requests are dropped.
  - A simultaneous request and dequeue leaves the count unchanged.
  - coin_pending = queue count.
- Reset mid-pulse: coin1 drops asynchronously and the queue is cleared.

Optional Feature:
- Macro: ARCADE_INPUT_AUTOFIRE_EN.
- When defined:
  - Adds input autofire (1 bit) and parameter AUTOFIRE_MS (default 50).
  - While autofire=1 and a player's raw fire is held, that player's fire output toggles every AUTOFIRE_MS ticks, starting at 1 on the press cycle.
  - Each player has an independent phase, which resets to 0 on release.
- When undefined: fire is passed through, and no extra port or logic exists.

Test Plan:
- Reset asserted mid-pulse: coin1=1 at 30 ms, reset_n low → coin1=0 immediately; after release, coin_pending=0 and all outputs are 0.
- Key decode: toggle with {pressed=1, ext=1, 75} → p1_ctrl=5'b01000 two clocks later; release event → 5'b00000. The same event with a repeated toggle value (no change) → no effect.
- Rotate remap: rotate=1, joystick_0[1]=1 (left) → p1_ctrl up bit = 1 and p2_ctrl up bit = 1; rotate=0 → the left bits are set instead.
- Coin timing: CLK_HZ=1000 (1 tick/clk), COIN_MS=4, GAP_MS=3, one start1 press → coin1 high for 4 ms±1 ms, then low for at least 3 ms; coin_pending goes 1→0 when the pulse starts.
- Coin queue: 5 coin-key presses within one pulse, QDEPTH=3 → exactly 1+3 pulses total, then coin_pending=0.
- Simultaneous event: a request arriving in the same cycle the FSM dequeues (queue=1) → queue stays 1, and the next pulse follows after the gap.
